// File: rtl/mod_phase_ctrl.sv
// Phase-select controller for a two-stage BUFGMUX tree fed by a phase DCM.
// Resets/relocks the DCM, then steps the mux selects one bit at a time with a settle hold.
module mod_phase_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_CYCLES  = 256
) (
  input  logic       USER_CLOCK,
  input  logic       RST_N,
  input  logic       DCM_LOCKED,
  input  logic [1:0] PHASE_REQ,
  input  logic       PHASE_REQ_VALID,
  input  logic       AUTO_EN,
  output logic       PHASE_REQ_READY,
  output logic       CLK_MOD_PHASE_SEL1,
  output logic       CLK_MOD_PHASE_SEL2,
  output logic [1:0] PHASE_CUR,
  output logic       PHASE_ACK,
  output logic       DCM_RST,
  output logic       LOCK_FAULT
);

  localparam int CMAX_A = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int CMAX   = (CMAX_A > SETTLE_CYCLES) ? CMAX_A : SETTLE_CYCLES;
  localparam int CNT_W  = $clog2(CMAX + 1);
  localparam int DW_W   = $clog2(DWELL_CYCLES + 1);

  typedef enum logic [2:0] {
    DCM_RESET, WAIT_LOCK, IDLE, SW_LO, SET_LO, SW_HI, SET_HI
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        tgt_q, tgt_d;
  logic              ack_q, ack_d;
  logic              fault_q, fault_d;
  logic              accept, auto_fire;
  logic [1:0]        next_tgt;

  always_ff @(posedge USER_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= DCM_RESET;
      cnt_q   <= '0;
      dwell_q <= '0;
      sel_q   <= 2'b00;
      tgt_q   <= 2'b00;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dwell_d   = '0;
    sel_d     = sel_q;
    tgt_d     = tgt_q;
    ack_d     = 1'b0;
    fault_d   = fault_q;
    accept    = (state_q == IDLE) && DCM_LOCKED && PHASE_REQ_VALID;
    auto_fire = (state_q == IDLE) && DCM_LOCKED && !PHASE_REQ_VALID && AUTO_EN &&
                (dwell_q == DW_W'(DWELL_CYCLES - 1));
    next_tgt  = accept ? PHASE_REQ : sel_q + 2'd1;

    unique case (state_q)
      DCM_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (DCM_LOCKED) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = DCM_RESET;
          cnt_d   = '0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (accept || auto_fire) begin
          tgt_d = next_tgt;
          if (next_tgt == sel_q)            ack_d   = 1'b1;
          else if (next_tgt[0] != sel_q[0]) state_d = SW_LO;
          else                              state_d = SW_HI;
        end else if (AUTO_EN) begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      SW_LO: begin
        sel_d[0] = tgt_q[0];
        state_d  = SET_LO;
        cnt_d    = '0;
      end
      SET_LO: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          if (tgt_q[1] != sel_q[1]) state_d = SW_HI;
          else begin
            state_d = IDLE;
            ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SW_HI: begin
        sel_d[1] = tgt_q[1];
        state_d  = SET_HI;
        cnt_d    = '0;
      end
      SET_HI: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DCM_RESET;
        cnt_d   = '0;
      end
    endcase

    // Lock loss overrides anything in progress: park muxes at phase 0 and re-reset the DCM.
    if (!DCM_LOCKED && (state_q != DCM_RESET) && (state_q != WAIT_LOCK)) begin
      state_d = DCM_RESET;
      cnt_d   = '0;
      sel_d   = 2'b00;
      ack_d   = 1'b0;
      dwell_d = '0;
    end
  end

  always_comb begin
    PHASE_REQ_READY    = (state_q == IDLE);
    DCM_RST            = (state_q == DCM_RESET);
    CLK_MOD_PHASE_SEL1 = sel_q[0];
    CLK_MOD_PHASE_SEL2 = sel_q[1];
    PHASE_CUR          = sel_q;
    PHASE_ACK          = ack_q;
    LOCK_FAULT         = fault_q;
  end

endmodule

// File: tb/tb_mod_phase_ctrl.sv
// Randomized bench for mod_phase_ctrl with a transaction-level phase/latency model.
module tb_mod_phase_ctrl;
  localparam int RC = 4;
  localparam int LT = 1024;
  localparam int SC = 8;
  localparam int DW = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b1;
  logic [1:0] req = 2'd0;
  logic       valid = 1'b0;
  logic       auto_en = 1'b0;
  logic       ready, sel1, sel2, ack, dcm_rst, fault;
  logic [1:0] cur;

  int checks = 0;
  int errors = 0;
  logic [1:0] model_cur = 2'd0;

  always #5 clk = ~clk;

  mod_phase_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .DWELL_CYCLES(DW)) dut (
    .USER_CLOCK(clk), .RST_N(rst_n), .DCM_LOCKED(locked), .PHASE_REQ(req),
    .PHASE_REQ_VALID(valid), .AUTO_EN(auto_en), .PHASE_REQ_READY(ready),
    .CLK_MOD_PHASE_SEL1(sel1), .CLK_MOD_PHASE_SEL2(sel2), .PHASE_CUR(cur),
    .PHASE_ACK(ack), .DCM_RST(dcm_rst), .LOCK_FAULT(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Switch time from the model: each changed select bit costs one switch cycle plus the settle.
  function automatic int switch_lat(input logic [1:0] from, input logic [1:0] to);
    int l = 0;
    if (from[0] != to[0]) l += SC + 1;
    if (from[1] != to[1]) l += SC + 1;
    return l;
  endfunction

  // Counts cycles from now until DCM_RST is seen low; also reports any ACK seen meanwhile.
  task automatic rst_pulse(output int n, output bit saw_ack);
    n = 0;
    saw_ack = 0;
    do begin
      tick();
      n++;
      if (ack) saw_ack = 1;
    end while (dcm_rst && n < 50);
  endtask

  task automatic wait_ready(output int n, output bit saw_ack);
    n = 0;
    saw_ack = 0;
    do begin
      tick();
      n++;
      if (ack) saw_ack = 1;
    end while (!ready && n < 50);
  endtask

  task automatic do_req(input logic [1:0] p, input bit noise);
    int n, t_lo, t_hi, exp_hi;
    bit bad;
    logic [1:0] prev;
    bit lo, hi;
    lo = (p[0] != model_cur[0]);
    hi = (p[1] != model_cur[1]);
    chk("ready_before_req", ready, 1);
    req = p;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    n = 0; t_lo = -1; t_hi = -1; bad = 0;
    prev = {sel2, sel1};
    while (!ack && n < 100) begin
      if (ready) bad = 1;
      if (noise) begin
        valid = 1'($urandom_range(0, 1));
        req = 2'($urandom_range(0, 3));
      end
      tick();
      n++;
      if (sel1 != prev[0] && sel2 != prev[1]) bad = 1;
      if (sel1 != prev[0] && t_lo < 0) t_lo = n;
      if (sel2 != prev[1] && t_hi < 0) t_hi = n;
      prev = {sel2, sel1};
    end
    valid = 1'b0;
    exp_hi = hi ? (lo ? SC + 2 : 1) : -1;
    chk("ack_latency", n, switch_lat(model_cur, p));
    chk("phase_cur", cur, p);
    chk("selects", {sel2, sel1}, p);
    chk("sel1_toggle_time", t_lo, lo ? 1 : -1);
    chk("sel2_toggle_time", t_hi, exp_hi);
    chk("busy_rules", bad, 0);
    tick();
    chk("ack_single_pulse", ack, 0);
    model_cur = p;
  endtask

  initial begin
    int n;
    bit sa;
    logic [1:0] nxt, p;

    // Reset state and bring-up
    repeat (3) tick();
    chk("rst_dcm_rst", dcm_rst, 1);
    chk("rst_ready", ready, 0);
    chk("rst_sel", {sel2, sel1}, 0);
    chk("rst_cur", cur, 0);
    chk("rst_ack", ack, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    rst_pulse(n, sa);
    chk("bringup_pulse_len", n, RC);
    wait_ready(n, sa);
    chk("bringup_ready_delay", n, 1);

    // Directed: 0 -> 3, then same-phase request
    do_req(2'd3, 1'b0);
    do_req(2'd3, 1'b0);

    // Randomized requests, half with ignored strobes while busy
    for (int i = 0; i < 24; i++) do_req(2'($urandom_range(0, 3)), (i % 2) == 1);
    do_req(model_cur, 1'b1);

    // Auto-rotation through all four phases
    if (model_cur != 2'd0) do_req(2'd0, 1'b0);
    auto_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      nxt = model_cur + 2'd1;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ack && n < DW + 100);
      chk("auto_ack_spacing", n, DW + switch_lat(model_cur, nxt));
      chk("auto_phase", cur, nxt);
      model_cur = nxt;
    end
    auto_en = 1'b0;
    tick();

    // Lock loss during SET_LO
    p = {1'($urandom_range(0, 1)), ~model_cur[0]};
    req = p;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat ($urandom_range(1, SC)) tick();
    chk("sel1_moved_before_drop", sel1, p[0]);
    locked = 1'b0;
    tick();
    chk("drop_sel", {sel2, sel1}, 0);
    chk("drop_cur", cur, 0);
    chk("drop_dcm_rst", dcm_rst, 1);
    chk("drop_ack", ack, 0);
    locked = 1'b1;
    rst_pulse(n, sa);
    chk("drop_pulse_len", n, RC);
    chk("drop_no_ack", sa, 0);
    wait_ready(n, sa);
    chk("drop_relock_ready", n, 1);
    chk("drop_no_ack_relock", sa, 0);
    model_cur = 2'd0;

    // Lock held low: timeout, fault, repeated DCM reset pulses
    locked = 1'b0;
    tick();
    chk("idle_drop_dcm_rst", dcm_rst, 1);
    rst_pulse(n, sa);
    chk("timeout_pulse1_len", n, RC);
    chk("fault_not_yet", fault, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fault && n < LT + 50);
    chk("lock_timeout_cycles", n, LT);
    chk("timeout_dcm_rst_again", dcm_rst, 1);
    rst_pulse(n, sa);
    chk("timeout_pulse2_len", n, RC);
    locked = 1'b1;
    wait_ready(n, sa);
    chk("fault_sticky", fault, 1);

    // Async reset mid-switch discards the target
    do_req(2'd1, 1'b0);
    req = 2'd2;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midsw_rst_sel", {sel2, sel1}, 0);
    chk("midsw_rst_dcm_rst", dcm_rst, 1);
    chk("midsw_rst_fault", fault, 0);
    chk("midsw_rst_ready", ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    rst_pulse(n, sa);
    chk("midsw_pulse_len", n, RC);
    wait_ready(n, sa);
    chk("midsw_no_ack", sa, 0);
    chk("midsw_cur", cur, 0);
    model_cur = 2'd0;
    do_req(2'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_phase_ctrl.md
MOD_PHASE_CTRL -- requirements
Module: mod_phase_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: DCM reset pulse length in USER_CLOCK cycles.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles to wait for DCM_LOCKED after a DCM reset.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8: hold time after each select-bit change.
REQ-004 SHALL have parameter DWELL_CYCLES, default 256: idle cycles between auto-rotate steps.
REQ-005 SHALL have port USER_CLOCK, input, 1: the single clock; all logic rises on it.
REQ-006 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port DCM_LOCKED, input, 1: lock status from the phase DCM.
REQ-008 SHALL have port PHASE_REQ, input, 2: requested phase code (0=0°, 1=90°, 2=180°, 3=270°).
REQ-009 SHALL have port PHASE_REQ_VALID, input, 1: request strobe.
REQ-010 SHALL have port AUTO_EN, input, 1: enable auto-rotation.
REQ-011 SHALL have port PHASE_REQ_READY, output, 1: request can be accepted.
REQ-012 SHALL have port CLK_MOD_PHASE_SEL1, output, 1: select for first-stage BUFGMUXes (equals phase bit 0).
REQ-013 SHALL have port CLK_MOD_PHASE_SEL2, output, 1: select for second-stage BUFGMUX (equals phase bit 1).
REQ-014 SHALL have port PHASE_CUR, output, 2: phase code currently applied to the muxes.
REQ-015 SHALL have port PHASE_ACK, output, 1: one-cycle pulse marking switch completion.
REQ-016 SHALL have port DCM_RST, output, 1: active-high DCM reset.
REQ-017 SHALL have port LOCK_FAULT, output, 1: sticky flag for lock timeout.

Function
REQ-018 SHALL implement states DCM_RESET, WAIT_LOCK, IDLE, SW_LO, SET_LO, SW_HI, SET_HI.
REQ-019 SHALL, in DCM_RESET, assert DCM_RST for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-020 SHALL, in WAIT_LOCK, go to IDLE on the first cycle DCM_LOCKED=1, or go to DCM_RESET and set LOCK_FAULT after LOCK_TIMEOUT cycles without lock.
REQ-021 SHALL drive PHASE_REQ_READY=1 only in IDLE; a request is accepted on a cycle with VALID=1 and READY=1, and the target is latched.
REQ-022 SHALL, when the accepted target equals PHASE_CUR, pulse PHASE_ACK on the next cycle and stay in IDLE.
REQ-023 SHALL switch bit 0 first (SW_LO, one cycle), hold it for SETTLE_CYCLES (SET_LO), then switch bit 1 (SW_HI) and hold it (SET_HI); a stage whose bit is unchanged is skipped. The two select outputs never change in the same cycle.
REQ-024 SHALL update PHASE_CUR together with the select output it mirrors.
REQ-025 SHALL pulse PHASE_ACK on the cycle that SET_HI (or SET_LO when SW_HI is skipped) returns to IDLE.
REQ-026 SHALL, with AUTO_EN=1 in IDLE, count idle cycles and after DWELL_CYCLES issue an internal target of (PHASE_CUR+1) mod 4, so that 3 wraps to 0; the 1->2 and 3->0 steps use both stages.
REQ-027 SHALL give an external request priority over an auto step in the same cycle, and clear the dwell counter on any switch or when AUTO_EN=0.
REQ-028 SHALL, when DCM_LOCKED=0 in IDLE or any switch state, abort the operation, force the selects and PHASE_CUR to 0, issue no ACK, and enter DCM_RESET.
REQ-029 SHALL ignore PHASE_REQ_VALID while READY=0, with no queuing.

Reset
REQ-030 SHALL, while RST_N=0, force state DCM_RESET with counter 0, DCM_RST=1, selects=0, PHASE_CUR=0, READY=0, PHASE_ACK=0, LOCK_FAULT=0, and dwell counter 0.
REQ-031 SHALL begin counting the RST_CYCLES pulse on the first clock edge after RST_N rises; reset mid-switch discards the pending target.

Verification
REQ-032 SHALL cover: release reset with DCM_LOCKED=1 -> DCM_RST high for 4 cycles, READY=1 one cycle after lock is seen.
REQ-033 SHALL cover: request 3 from phase 0 -> SEL1 rises, SEL2 rises 9 cycles later, ACK one cycle after the final 8-cycle settle, PHASE_CUR=3.
REQ-034 SHALL cover: request equal to PHASE_CUR -> ACK next cycle with no select toggle.
REQ-035 SHALL cover: AUTO_EN=1 with DWELL=256 -> phase sequence 0,1,2,3,0, each ACK spaced by dwell plus settle time.
REQ-036 SHALL cover: DCM_LOCKED dropped during SET_LO -> selects go to 0, no ACK, DCM_RST pulses again.
REQ-037 SHALL cover: DCM_LOCKED held 0 -> LOCK_FAULT=1 after 1024 cycles of WAIT_LOCK, and DCM_RST pulses repeat.
